// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and sizing helpers for the TX frame scheduler and its tick generator.
package tx_sched_pkg;
  localparam int UART_DATA_WIDTH     = 8;
  localparam int FRAME_TOTAL_LEN     = 16;
  localparam int DEF_SAMPLES_PER_BIT = 64;
  localparam int DEF_SAMPLE_DIV      = 50;
  localparam int DEF_GAP_BITS        = 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_e;
  typedef logic bank_idx_t;

  // Bits needed to hold max_val; never below one bit so degenerate sizes still elaborate.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Bus bundle between the scheduler (slave view) and its UART / frame_and_diff / modulator neighbours.
interface tx_frame_scheduler_if;
  import tx_sched_pkg::*;

  logic [UART_DATA_WIDTH-1:0] uart_in_data;
  logic                       uart_in_valid;
  logic                       uart_in_ready;
  logic [UART_DATA_WIDTH-1:0] fad_data;
  logic                       fad_valid;
  logic                       fad_ready;
  logic                       diff_valid;
  logic                       diff_data;
  logic                       mod_strobe;
  logic                       mod_bit;
  logic                       mod_bit_valid;
  logic                       mod_frame_start;
  logic                       frame_done;
  logic                       overrun;

  modport slave (
    input  uart_in_data, uart_in_valid, fad_ready, diff_valid, diff_data,
    output uart_in_ready, fad_data, fad_valid, mod_strobe, mod_bit,
           mod_bit_valid, mod_frame_start, frame_done, overrun
  );

  modport master (
    output uart_in_data, uart_in_valid, fad_ready, diff_valid, diff_data,
    input  uart_in_ready, fad_data, fad_valid, mod_strobe, mod_bit,
           mod_bit_valid, mod_frame_start, frame_done, overrun
  );
endinterface

// File: rtl/tx_frame_scheduler_fs_tick_gen.sv
// Free-running divider producing a one-cycle tick every SAMPLE_DIV sys_clk cycles.
module fs_tick_gen
  import tx_sched_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic sys_clk,
  input  logic rst,
  output logic tick
);
  localparam int            CW      = cnt_w(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_MAX);
endmodule

// File: rtl/tx_frame_scheduler.sv
// Ping-pong bit buffer between frame_and_diff bursts and the DPSK modulator, paced at the fs strobe.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int FRAME_LEN       = FRAME_TOTAL_LEN,
  parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
  parameter int SAMPLE_DIV      = DEF_SAMPLE_DIV,
  parameter int GAP_BITS        = DEF_GAP_BITS
) (
  input  logic               sys_clk,
  input  logic               rst,
  tx_frame_scheduler_if.slave bus
);
  localparam int GAP_TICKS = GAP_BITS * SAMPLES_PER_BIT;
  localparam int BW        = cnt_w(FRAME_LEN - 1);
  localparam int SW        = cnt_w(SAMPLES_PER_BIT - 1);
  localparam int GW        = cnt_w((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  logic                 tick;
  logic [FRAME_LEN-1:0] bank_mem [2];
  logic [1:0]           bank_full, full_n;
  bank_idx_t            wr_sel, rd_sel, rd_sel_n;
  logic [BW-1:0]        wr_ptr, bit_idx, bit_n, adv_bit;
  logic [SW-1:0]        samp_idx, samp_n, adv_samp;
  logic [GW-1:0]        gap_cnt, gap_n;
  tx_state_e            state, state_n;
  logic                 wr_free, wr_fire, wr_last, samp_wrap;
  logic                 bit_out_n, vld_n, start_n, done_n;
  logic                 strobe_p1, bit_p1, bit_vld_p1, start_p1, done_p1, overrun_q;

  fs_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .sys_clk (sys_clk),
    .rst     (rst),
    .tick    (tick)
  );

  // A bank only fills on the last bit of its burst, so wr_free is stable for a whole frame.
  assign wr_free = !bank_full[wr_sel];
  assign wr_fire = bus.diff_valid & wr_free;
  assign wr_last = wr_fire & (wr_ptr == BIT_LAST);

  assign bus.fad_data      = bus.uart_in_data;
  assign bus.fad_valid     = bus.uart_in_valid & wr_free;
  assign bus.uart_in_ready = bus.fad_ready & wr_free;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      bank_mem  <= '{default: '0};
      wr_ptr    <= '0;
      wr_sel    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        bank_mem[wr_sel][wr_ptr] <= bus.diff_data;
        wr_ptr                   <= wr_last ? '0 : wr_ptr + 1'b1;
        if (wr_last) wr_sel <= ~wr_sel;
      end
      if (bus.diff_valid && !wr_free) overrun_q <= 1'b1;
    end
  end

  assign samp_wrap = (samp_idx == SAMP_LAST);
  assign adv_samp  = samp_wrap ? '0 : samp_idx + 1'b1;
  assign adv_bit   = samp_wrap ? bit_idx + 1'b1 : bit_idx;

  // Read sequencer: every decision is taken on tick and lands with the registered strobe.
  always_comb begin
    state_n   = state;
    rd_sel_n  = rd_sel;
    bit_n     = bit_idx;
    samp_n    = samp_idx;
    gap_n     = gap_cnt;
    full_n    = bank_full;
    bit_out_n = bit_p1;
    vld_n     = bit_vld_p1;
    start_n   = 1'b0;
    done_n    = 1'b0;
    if (wr_last) full_n[wr_sel] = 1'b1;
    if (tick) begin
      case (state)
        IDLE: begin
          vld_n = 1'b0;
          if (bank_full[rd_sel]) begin
            state_n   = SEND;
            bit_n     = '0;
            samp_n    = '0;
            start_n   = 1'b1;
            vld_n     = 1'b1;
            bit_out_n = bank_mem[rd_sel][0];
          end
        end
        SEND: begin
          bit_n     = adv_bit;
          samp_n    = adv_samp;
          vld_n     = 1'b1;
          bit_out_n = bank_mem[rd_sel][adv_bit];
          if (adv_bit == BIT_LAST && adv_samp == SAMP_LAST) begin
            done_n         = 1'b1;
            full_n[rd_sel] = 1'b0;
            rd_sel_n       = ~rd_sel;
            gap_n          = '0;
            // With no gap, IDLE picks up a queued bank on the very next tick.
            state_n        = (GAP_BITS > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          vld_n = 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state_n = IDLE;
            gap_n   = '0;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output stage p1: strobe and bit fields leave together, one clock after tick.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rd_sel     <= 1'b0;
      bit_idx    <= '0;
      samp_idx   <= '0;
      gap_cnt    <= '0;
      bank_full  <= '0;
      strobe_p1  <= 1'b0;
      bit_p1     <= 1'b0;
      bit_vld_p1 <= 1'b0;
      start_p1   <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      state      <= state_n;
      rd_sel     <= rd_sel_n;
      bit_idx    <= bit_n;
      samp_idx   <= samp_n;
      gap_cnt    <= gap_n;
      bank_full  <= full_n;
      strobe_p1  <= tick;
      bit_p1     <= bit_out_n;
      bit_vld_p1 <= vld_n;
      start_p1   <= start_n;
      done_p1    <= done_n;
    end
  end

  assign bus.mod_strobe      = strobe_p1;
  assign bus.mod_bit         = bit_p1;
  assign bus.mod_bit_valid   = bit_vld_p1;
  assign bus.mod_frame_start = start_p1;
  assign bus.frame_done      = done_p1;
  assign bus.overrun         = overrun_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed-random bench: strobe-level log of each scheduler checked against expected frame sequences.
module tb_tx_frame_scheduler;
  import tx_sched_pkg::*;

  localparam int FL  = 16;
  localparam int SPB = 4;
  localparam int SD  = 5;
  localparam int GB  = 2;
  localparam int FS  = FL * SPB;
  localparam int GS  = GB * SPB;

  typedef struct packed {logic v; logic b; logic s; logic d;} strobe_t;
  typedef struct {logic [FL-1:0] bits; int lead;} exp_t;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  logic rst0    = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  strobe_t log1[$];
  strobe_t log0[$];
  exp_t    exp1[$];
  exp_t    exp0[$];

  tx_frame_scheduler_if bus  ();
  tx_frame_scheduler_if bus0 ();

  tx_frame_scheduler #(.FRAME_LEN(FL), .SAMPLES_PER_BIT(SPB), .SAMPLE_DIV(SD), .GAP_BITS(GB)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  tx_frame_scheduler #(.FRAME_LEN(FL), .SAMPLES_PER_BIT(SPB), .SAMPLE_DIV(SD), .GAP_BITS(0)) dut0 (
    .sys_clk (sys_clk),
    .rst     (rst0),
    .bus     (bus0.slave)
  );

  assign bus0.uart_in_data  = bus.uart_in_data;
  assign bus0.uart_in_valid = bus.uart_in_valid;
  assign bus0.fad_ready     = bus.fad_ready;
  assign bus0.diff_valid    = bus.diff_valid;
  assign bus0.diff_data     = bus.diff_data;

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (bus.mod_strobe)
      log1.push_back(strobe_t'({bus.mod_bit_valid, bus.mod_bit, bus.mod_frame_start, bus.frame_done}));
    if (bus0.mod_strobe)
      log0.push_back(strobe_t'({bus0.mod_bit_valid, bus0.mod_bit, bus0.mod_frame_start, bus0.frame_done}));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_burst(input logic [FL-1:0] f);
    for (int i = 0; i < FL; i++) begin
      @(negedge sys_clk);
      bus.diff_valid = 1'b1;
      bus.diff_data  = f[i];
    end
    @(negedge sys_clk);
    bus.diff_valid = 1'b0;
    bus.diff_data  = 1'b0;
  endtask

  task automatic gate_check(input string tag, input logic exp_free);
    logic fr, uv;
    logic [UART_DATA_WIDTH-1:0] ud;
    fr = 1'($urandom_range(0, 1));
    uv = 1'($urandom_range(0, 1));
    ud = UART_DATA_WIDTH'($urandom);
    bus.fad_ready     = fr;
    bus.uart_in_valid = uv;
    bus.uart_in_data  = ud;
    #1;
    chk(tag, {bus.uart_in_ready, bus.fad_valid, bus.fad_data}, {fr & exp_free, uv & exp_free, ud});
  endtask

  function automatic int count_valid(input strobe_t q[$]);
    int n = 0;
    foreach (q[i]) if (q[i].v) n++;
    return n;
  endfunction

  // Walk the strobe log: idle strobes, then each expected frame as FS strobes plus its gap.
  task automatic check_log(input string tag, input strobe_t lg[$], input exp_t ex[$], input int gs);
    int idx = 0;
    int run = 0;
    int nf = 0;
    int n_exp = ex.size();
    int ng;
    logic stray = 1'b0;
    logic [FS-1:0] ov, ob, os, od, eb, es, ed;
    logic [63:0] gv, gb;
    exp_t e;
    while (idx < lg.size()) begin
      if (!lg[idx].v) begin
        stray |= lg[idx].s | lg[idx].d;
        run++;
        idx++;
      end else if (ex.size() == 0 || idx + FS > lg.size()) begin
        if (ex.size() == 0) nf++;
        idx = lg.size();
      end else begin
        e = ex.pop_front();
        for (int k = 0; k < FS; k++) begin
          ov[k] = lg[idx+k].v;
          ob[k] = lg[idx+k].b;
          os[k] = lg[idx+k].s;
          od[k] = lg[idx+k].d;
          eb[k] = e.bits[k/SPB];
          es[k] = (k == 0);
          ed[k] = (k == FS - 1);
        end
        chk($sformatf("%s_f%0d_bits", tag, nf), ob, eb);
        chk($sformatf("%s_f%0d_valid", tag, nf), ov, {FS{1'b1}});
        chk($sformatf("%s_f%0d_start", tag, nf), os, es);
        chk($sformatf("%s_f%0d_done", tag, nf), od, ed);
        if (e.lead >= 0) chk($sformatf("%s_f%0d_lead", tag, nf), run, e.lead);
        idx += FS;
        nf++;
        gv = '0;
        gb = '0;
        ng = 0;
        while (ng < gs && idx < lg.size()) begin
          gv[ng] = lg[idx].v;
          gb[ng] = lg[idx].b;
          stray |= lg[idx].s | lg[idx].d;
          idx++;
          ng++;
        end
        if (gs > 0) begin
          chk($sformatf("%s_f%0d_gap_len", tag, nf - 1), ng, gs);
          chk($sformatf("%s_f%0d_gap_valid", tag, nf - 1), gv, 64'd0);
          chk($sformatf("%s_f%0d_gap_hold", tag, nf - 1), gb,
              e.bits[FL-1] ? ((64'd1 << gs) - 64'd1) : 64'd0);
        end
        run = ng;
      end
    end
    chk({tag, "_frames"}, nf, n_exp);
    chk({tag, "_stray_pulse"}, stray, 1'b0);
  endtask

  initial begin
    logic [FL-1:0] f1, f2, f3, fc;
    int  n;
    logic found, prev_rdy;

    bus.uart_in_data  = '0;
    bus.uart_in_valid = 1'b0;
    bus.fad_ready     = 1'b1;
    bus.diff_valid    = 1'b0;
    bus.diff_data     = 1'b0;

    // Reset state and first strobe after release
    wait_clk(10);
    chk("reset_outs", {bus.mod_strobe, bus.mod_bit, bus.mod_bit_valid,
                       bus.mod_frame_start, bus.frame_done, bus.overrun}, 64'd0);
    chk("reset_ready", bus.uart_in_ready, 1'b1);
    rst = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < SD + 5) begin
      @(negedge sys_clk);
      n++;
      found = bus.mod_strobe;
    end
    chk("first_strobe_edges", n, SD);

    // Single known frame
    gate_check("gate_empty", 1'b1);
    bus.uart_in_valid = 1'b0;
    bus.fad_ready     = 1'b1;
    log1.delete();
    send_burst(16'h5AC3);
    exp1.push_back('{16'h5AC3, -1});
    n = 0;
    found = 1'b0;
    while (!found && n < SD + 3) begin
      @(negedge sys_clk);
      n++;
      found = bus.mod_strobe & bus.mod_bit_valid;
    end
    chk("latency_bound", found && (n <= SD + 2), 1'b1);
    wait_clk((FS + GS + 4) * SD);
    check_log("single", log1, exp1, GS);
    log1.delete();
    exp1.delete();

    // Ping-pong: two banks fill, upstream stalls until the first bank frees
    f1 = FL'($urandom);
    f2 = FL'($urandom);
    f3 = FL'($urandom);
    send_burst(f1);
    send_burst(f2);
    exp1.push_back('{f1, -1});
    exp1.push_back('{f2, GS});
    exp1.push_back('{f3, GS});
    gate_check("gate_full", 1'b0);
    bus.uart_in_valid = 1'b0;
    bus.fad_ready     = 1'b1;
    #1;
    n = 0;
    prev_rdy = bus.uart_in_ready;
    while (!bus.frame_done && n < 2000) begin
      prev_rdy = bus.uart_in_ready;
      @(negedge sys_clk);
      n++;
    end
    chk("pp_done_seen", bus.frame_done, 1'b1);
    chk("pp_ready_before_free", prev_rdy, 1'b0);
    chk("pp_ready_after_free", bus.uart_in_ready, 1'b1);
    send_burst(f3);
    wait_clk((2 * (FS + GS) + 8) * SD);
    chk("pp_no_overrun", bus.overrun, 1'b0);
    check_log("pingpong", log1, exp1, GS);
    log1.delete();
    exp1.delete();

    // Overrun: extra bit while both banks hold frames
    f1 = FL'($urandom);
    f2 = FL'($urandom);
    send_burst(f1);
    send_burst(f2);
    exp1.push_back('{f1, -1});
    exp1.push_back('{f2, GS});
    chk("ovr_before", bus.overrun, 1'b0);
    bus.diff_valid = 1'b1;
    bus.diff_data  = 1'($urandom_range(0, 1));
    @(negedge sys_clk);
    bus.diff_valid = 1'b0;
    chk("ovr_set", bus.overrun, 1'b1);
    wait_clk((2 * (FS + GS) + 8) * SD);
    chk("ovr_sticky", bus.overrun, 1'b1);
    check_log("overrun", log1, exp1, GS);
    log1.delete();
    exp1.delete();

    // Reset in the middle of bit 5
    fc = FL'($urandom);
    send_burst(fc);
    n = 0;
    while (count_valid(log1) < 5 * SPB + 1 && n < 600) begin
      @(negedge sys_clk);
      n++;
    end
    chk("mid_bit5", bus.mod_bit, fc[5]);
    rst = 1'b0;
    #1;
    bus.fad_ready = 1'($urandom_range(0, 1));
    #1;
    chk("rst_mid_outs", {bus.mod_strobe, bus.mod_bit, bus.mod_bit_valid,
                         bus.mod_frame_start, bus.frame_done, bus.overrun}, 64'd0);
    chk("rst_mid_ready", bus.uart_in_ready, bus.fad_ready);
    @(negedge sys_clk);
    chk("rst_mid_outs_next", {bus.mod_strobe, bus.mod_bit_valid, bus.overrun}, 64'd0);
    wait_clk(3);
    rst = 1'b1;
    log1.delete();
    exp1.delete();
    bus.fad_ready = 1'b1;
    gate_check("gate_after_rst", 1'b1);
    bus.uart_in_valid = 1'b0;
    bus.fad_ready     = 1'b1;
    f1 = FL'($urandom);
    send_burst(f1);
    exp1.push_back('{f1, -1});
    wait_clk((FS + GS + 8) * SD);
    check_log("after_rst", log1, exp1, GS);
    log1.delete();
    exp1.delete();

    // Zero-gap instance: queued frames play back to back
    rst0 = 1'b1;
    wait_clk(2);
    f1 = FL'($urandom);
    f2 = FL'($urandom);
    send_burst(f1);
    send_burst(f2);
    exp0.push_back('{f1, -1});
    exp0.push_back('{f2, 0});
    wait_clk((2 * FS + 10) * SD);
    check_log("gap0", log0, exp0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
